// File: rtl/wf_playback_ctrl.sv
// rtl/wf_playback_ctrl.sv - waveform stream to DAC playback controller
// Plays one frame per trigger, turning stream gaps into flagged zero samples.
module wf_playback_ctrl #(
  parameter int LEN_WIDTH  = 16,
  parameter int DLY_WIDTH  = 16,
  parameter int FCNT_WIDTH = 16
) (
  input  logic                  clk_in1,
  input  logic                  aresetn,
  input  logic                  trigger,
  input  logic [LEN_WIDTH-1:0]  wf_len,
  input  logic [DLY_WIDTH-1:0]  start_delay,
  input  logic                  clear_errors,
  input  logic                  wf_read_ready,
  input  logic [31:0]           wfout_axis_tdata,
  input  logic                  wfout_axis_tvalid,
  input  logic                  wfout_axis_tlast,
  input  logic [3:0]            wfout_axis_tkeep,
  output logic                  wfout_axis_tready,
  output logic [15:0]           dac_i,
  output logic [15:0]           dac_q,
  output logic                  dac_valid,
  output logic                  busy,
  output logic                  frame_done,
  output logic [FCNT_WIDTH-1:0] frame_count,
  output logic                  underflow_err,
  output logic                  tlast_err,
  output logic                  trig_overrun_err
);

  typedef enum logic [2:0] {IDLE, WAIT_RDY, DELAY, PLAY, DONE} state_t;

  state_t               state;
  state_t               state_nxt;
  logic [LEN_WIDTH-1:0] len_q;
  logic [LEN_WIDTH-1:0] beat_idx;
  logic [DLY_WIDTH-1:0] dly_cnt;
  logic                 trig_accept;
  logic                 beat_acc;
  logic                 last_beat;
  logic                 early_last;
  logic                 tlast_miss;
  logic                 gap;
  logic                 trig_overrun;
  logic                 unused_tkeep;

  // Every beat is a full 32-bit word, so tkeep carries no information.
  assign unused_tkeep = ^wfout_axis_tkeep;

  assign wfout_axis_tready = (state == PLAY);
  assign busy              = (state != IDLE);
  assign trig_overrun      = trigger && (state != IDLE);

  always_ff @(posedge clk_in1 or negedge aresetn) begin
    if (!aresetn) begin
      state <= IDLE;
    end else begin
      state <= state_nxt;
    end
  end

  always_comb begin
    state_nxt   = state;
    trig_accept = 1'b0;
    beat_acc    = 1'b0;
    last_beat   = 1'b0;
    early_last  = 1'b0;
    tlast_miss  = 1'b0;
    gap         = 1'b0;
    case (state)
      IDLE: begin
        if (trigger && (wf_len != '0)) begin
          trig_accept = 1'b1;
          state_nxt   = WAIT_RDY;
        end
      end
      WAIT_RDY: begin
        if (wf_read_ready) begin
          state_nxt = (dly_cnt != '0) ? DELAY : PLAY;
        end
      end
      DELAY: begin
        if (dly_cnt == DLY_WIDTH'(1)) begin
          state_nxt = PLAY;
        end
      end
      PLAY: begin
        if (wfout_axis_tvalid) begin
          beat_acc   = 1'b1;
          last_beat  = (beat_idx == len_q - LEN_WIDTH'(1));
          early_last = wfout_axis_tlast && !last_beat;
          tlast_miss = last_beat && !wfout_axis_tlast;
          if (last_beat || early_last) begin
            state_nxt = DONE;
          end
        end else begin
          gap = 1'b1;
        end
      end
      DONE: begin
        state_nxt = IDLE;
      end
      default: begin
        state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk_in1 or negedge aresetn) begin
    if (!aresetn) begin
      len_q            <= '0;
      beat_idx         <= '0;
      dly_cnt          <= '0;
      dac_i            <= '0;
      dac_q            <= '0;
      dac_valid        <= 1'b0;
      frame_done       <= 1'b0;
      frame_count      <= '0;
      underflow_err    <= 1'b0;
      tlast_err        <= 1'b0;
      trig_overrun_err <= 1'b0;
    end else begin
      if (trig_accept) begin
        len_q    <= wf_len;
        dly_cnt  <= start_delay;
        beat_idx <= '0;
      end
      if (state == DELAY) begin
        dly_cnt <= dly_cnt - DLY_WIDTH'(1);
      end
      if (beat_acc) begin
        beat_idx <= beat_idx + LEN_WIDTH'(1);
      end
      // Every PLAY cycle yields a sample; gaps are emitted as zeros.
      dac_valid  <= (state == PLAY);
      dac_i      <= beat_acc ? wfout_axis_tdata[31:16] : 16'h0000;
      dac_q      <= beat_acc ? wfout_axis_tdata[15:0]  : 16'h0000;
      frame_done <= (state == DONE);
      if (state == DONE) begin
        frame_count <= frame_count + FCNT_WIDTH'(1);
      end
      underflow_err    <= (underflow_err & ~clear_errors) | gap;
      tlast_err        <= (tlast_err & ~clear_errors) | early_last | tlast_miss;
      trig_overrun_err <= (trig_overrun_err & ~clear_errors) | trig_overrun;
    end
  end

endmodule

// File: tb/tb_wf_playback_ctrl.sv
// tb/tb_wf_playback_ctrl.sv - self-checking bench for wf_playback_ctrl
// Expected sample streams are built from frame rules, checked every valid cycle.
module tb_wf_playback_ctrl;

  logic        clk_in1 = 1'b0;
  logic        aresetn = 1'b0;
  logic        trigger = 1'b0;
  logic [15:0] wf_len = '0;
  logic [15:0] start_delay = '0;
  logic        clear_errors = 1'b0;
  logic        wf_read_ready = 1'b0;
  logic [31:0] tdata = '0;
  logic        tvalid = 1'b0;
  logic        tlast = 1'b0;
  logic [3:0]  tkeep = 4'hF;
  logic        tready;
  logic [15:0] dac_i;
  logic [15:0] dac_q;
  logic        dac_valid;
  logic        busy;
  logic        frame_done;
  logic [15:0] frame_count;
  logic        uf_err;
  logic        tl_err;
  logic        ov_err;

  int tests = 0;
  int fails = 0;

  logic [31:0] exp_q[$];
  int n_samp = 0;
  int n_zero = 0;
  int src_beat = 0;
  int src_pc = 0;
  int gap_s = 1000000;
  int gap_n = 0;
  int tlast_at = 127;
  bit last_rdy = 1'b0;
  bit last_v = 1'b0;

  wf_playback_ctrl #(.LEN_WIDTH(16), .DLY_WIDTH(16), .FCNT_WIDTH(16)) dut (
    .clk_in1(clk_in1), .aresetn(aresetn), .trigger(trigger), .wf_len(wf_len),
    .start_delay(start_delay), .clear_errors(clear_errors), .wf_read_ready(wf_read_ready),
    .wfout_axis_tdata(tdata), .wfout_axis_tvalid(tvalid), .wfout_axis_tlast(tlast),
    .wfout_axis_tkeep(tkeep), .wfout_axis_tready(tready), .dac_i(dac_i), .dac_q(dac_q),
    .dac_valid(dac_valid), .busy(busy), .frame_done(frame_done), .frame_count(frame_count),
    .underflow_err(uf_err), .tlast_err(tl_err), .trig_overrun_err(ov_err)
  );

  always #5 clk_in1 = ~clk_in1;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h)", name, act, act, exp, exp);
    end
  endtask

  // Stream source: beat n carries I=0x1000+n, Q=n; tvalid drops on gap cycles of PLAY.
  always @(negedge clk_in1) begin
    if (last_rdy) begin
      src_pc++;
      if (last_v) src_beat++;
    end
    tvalid   = !(src_pc >= gap_s && src_pc < gap_s + gap_n);
    tdata    = {16'h1000 + 16'(src_beat), 16'(src_beat)};
    tlast    = (src_beat == tlast_at);
    last_rdy = tready;
    last_v   = tvalid;
  end

  // Reference frame: each PLAY cycle yields a gap zero or the next beat, until
  // wf_len beats are taken or an early tlast cuts the frame short.
  task automatic build_exp(input int len, input int tl_at, input int gs, input int gn);
    int b;
    int k;
    b = 0;
    k = 0;
    exp_q.delete();
    while (b < len) begin
      if (k >= gs && k < gs + gn) begin
        exp_q.push_back(32'h0);
      end else begin
        exp_q.push_back({16'h1000 + 16'(b), 16'(b)});
        b++;
        if (b - 1 == tl_at && b < len) break;
      end
      k++;
    end
  endtask

  always @(negedge clk_in1) begin
    if (aresetn && dac_valid) begin
      if (exp_q.size() == 0) begin
        check("unexpected_sample", {dac_i, dac_q}, 64'hFFFF_FFFF_FFFF);
      end else begin
        check("sample", {dac_i, dac_q}, exp_q.pop_front());
      end
      n_samp++;
      if ({dac_i, dac_q} == 32'h0) n_zero++;
    end
  end

  task automatic prep(input int len, input int tl_at, input int gs, input int gn);
    @(negedge clk_in1);
    #1;
    build_exp(len, tl_at, gs, gn);
    tlast_at = tl_at;
    gap_s    = gs;
    gap_n    = gn;
    src_beat = 0;
    src_pc   = 0;
    last_rdy = 1'b0;
    n_samp   = 0;
    n_zero   = 0;
  endtask

  task automatic fire(input int len, input int dly);
    @(negedge clk_in1);
    wf_len      = 16'(len);
    start_delay = 16'(dly);
    trigger     = 1'b1;
    @(negedge clk_in1);
    trigger     = 1'b0;
  endtask

  task automatic wait_done(input string name);
    int cyc;
    cyc = 0;
    while (!frame_done && cyc < 2000) begin
      @(negedge clk_in1);
      cyc++;
    end
    if (!frame_done) check({name, "_done_timeout"}, 0, 1);
  endtask

  task automatic clear();
    @(negedge clk_in1);
    clear_errors = 1'b1;
    @(negedge clk_in1);
    clear_errors = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int lat;
    repeat (3) @(negedge clk_in1);
    check("rst_tready", tready, 0);
    check("rst_dac_valid", dac_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_frame_count", frame_count, 0);
    check("rst_errs", {uf_err, tl_err, ov_err, frame_done}, 0);
    aresetn = 1'b1;

    // Plain frame, no delay, ready already high.
    wf_read_ready = 1'b1;
    prep(128, 127, 1000000, 0);
    fire(128, 0);
    lat = 0;
    while (!dac_valid && lat < 20) begin
      @(negedge clk_in1);
      lat++;
    end
    check("t1_latency", lat, 2);
    wait_done("t1");
    check("t1_samples", n_samp, 128);
    check("t1_frame_count", frame_count, 1);
    check("t1_dac_valid_at_done", dac_valid, 0);
    check("t1_errs", {uf_err, tl_err, ov_err}, 0);
    check("t1_leftover", exp_q.size(), 0);
    @(negedge clk_in1);
    check("t1_busy_after", busy, 0);
    check("t1_done_pulse", frame_done, 0);

    // Start delay of 5 after a late ready.
    wf_read_ready = 1'b0;
    prep(128, 127, 1000000, 0);
    fire(128, 5);
    repeat (8) @(negedge clk_in1);
    check("t2_waiting_busy", busy, 1);
    check("t2_waiting_tready", tready, 0);
    wf_read_ready = 1'b1;
    @(negedge clk_in1);
    lat = 0;
    while (!tready && lat < 20) begin
      @(negedge clk_in1);
      lat++;
    end
    check("t2_delay_cycles", lat, 5);
    wait_done("t2");
    check("t2_samples", n_samp, 128);
    check("t2_frame_count", frame_count, 2);

    // Three-cycle gap mid-frame.
    prep(128, 127, 40, 3);
    fire(128, 0);
    wait_done("t3");
    check("t3_samples", n_samp, 131);
    check("t3_zero_samples", n_zero, 3);
    check("t3_data_samples", n_samp - n_zero, 128);
    check("t3_underflow", uf_err, 1);
    check("t3_tlast_err", tl_err, 0);
    clear();
    check("t3_underflow_cleared", uf_err, 0);

    // Early tlast on beat 63.
    prep(128, 63, 1000000, 0);
    fire(128, 0);
    wait_done("t4a");
    check("t4a_samples", n_samp, 64);
    check("t4a_tlast_err", tl_err, 1);
    check("t4a_frame_count", frame_count, 4);
    @(negedge clk_in1);
    check("t4a_idle", busy, 0);
    clear();

    // Missing tlast on the final beat.
    prep(128, -1, 1000000, 0);
    fire(128, 0);
    wait_done("t4b");
    check("t4b_samples", n_samp, 128);
    check("t4b_tlast_err", tl_err, 1);
    clear();

    // Trigger during PLAY is an overrun and does not disturb the frame.
    prep(128, 127, 1000000, 0);
    fire(128, 0);
    repeat (20) @(negedge clk_in1);
    wf_len  = 16'd5;
    trigger = 1'b1;
    @(negedge clk_in1);
    trigger = 1'b0;
    check("t5_overrun", ov_err, 1);
    wait_done("t5");
    check("t5_samples", n_samp, 128);
    check("t5_frame_count", frame_count, 6);
    clear();
    check("t5_overrun_cleared", ov_err, 0);
    fire(0, 0);
    check("t5_len0_busy", busy, 0);
    @(negedge clk_in1);
    check("t5_len0_busy2", busy, 0);
    check("t5_len0_noflag", ov_err, 0);

    // Asynchronous reset in the middle of PLAY.
    prep(128, 127, 1000000, 0);
    fire(128, 0);
    repeat (30) @(negedge clk_in1);
    #2;
    aresetn = 1'b0;
    #1;
    check("t6_rst_tready", tready, 0);
    check("t6_rst_dac_valid", dac_valid, 0);
    check("t6_rst_busy", busy, 0);
    check("t6_rst_frame_count", frame_count, 0);
    check("t6_rst_done", frame_done, 0);
    repeat (2) @(negedge clk_in1);
    aresetn = 1'b1;
    prep(128, 127, 1000000, 0);
    fire(128, 0);
    wait_done("t6");
    check("t6_samples", n_samp, 128);
    check("t6_frame_count", frame_count, 1);
    check("t6_errs", {uf_err, tl_err, ov_err}, 0);

    repeat (3) @(negedge clk_in1);
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule

// File: doc/wf_playback_ctrl.md
Name: wf_playback_ctrl

Overview:
Downstream consumer of the waveform BRAM stream (wfout_axis). On a chirp trigger it waits for the waveform to be readable, applies a programmable start delay, then streams exactly one frame of packed I/Q words to the DAC sample interface. It runs continuously once started: stream gaps become zero samples and are flagged, never stalled. It checks frame length against tlast and reports errors to the register bank.

Parameters:
LEN_WIDTH, 16, width of frame length and sample counter
DLY_WIDTH, 16, width of start-delay counter
FCNT_WIDTH, 16, width of completed-frame counter

Ports:
clk_in1  in  1  sample clock (245.76 MHz domain)
aresetn  in  1  reset, asynchronous assert, active-low
trigger  in  1  single-cycle start pulse (chirp_init)
wf_len  in  LEN_WIDTH  frame length in 32-bit beats, sampled on accepted trigger
start_delay  in  DLY_WIDTH  cycles between ready and first sample, sampled on accepted trigger
clear_errors  in  1  clears sticky error flags
wf_read_ready  in  1  waveform_stream read side ready
wfout_axis_tdata  in  32  [31:16]=I, [15:0]=Q
wfout_axis_tvalid  in  1  stream valid
wfout_axis_tlast  in  1  end of frame
wfout_axis_tkeep  in  4  ignored (all beats are full)
wfout_axis_tready  out  1  stream ready
dac_i  out  16  I sample
dac_q  out  16  Q sample
dac_valid  out  1  DAC sample strobe
busy  out  1  not in IDLE
frame_done  out  1  one-cycle pulse at end of frame
frame_count  out  FCNT_WIDTH  completed frames, wraps
underflow_err  out  1  sticky
tlast_err  out  1  sticky
trig_overrun_err  out  1  sticky

Behaviour:
- Reset values: all outputs 0. The state machine is in IDLE and the internal counters are 0. Reset asserted mid-frame forces tready low immediately and abandons the frame. No frame_done is produced for the abandoned frame.
- States: IDLE, WAIT_RDY, DELAY, PLAY, DONE.
- IDLE: trigger=1 with wf_len!=0 latches wf_len and start_delay, then moves to WAIT_RDY. trigger with wf_len==0 is ignored and sets no flag.
- WAIT_RDY: when wf_read_ready=1, go to DELAY if the latched delay is nonzero, otherwise go to PLAY. The controller waits here indefinitely.
- DELAY: decrement the delay counter each cycle. Move to PLAY in the cycle the counter reads 1, so there are exactly start_delay cycles before PLAY.
- PLAY, tready: tready=1 combinationally in PLAY only.
- PLAY, accepted beat (tvalid & tready): registered one cycle later as dac_i=tdata[31:16], dac_q=tdata[15:0], dac_valid=1. Latency is 1 cycle. The beat index increments.
- PLAY, gap (tvalid=0): next cycle outputs dac_i=dac_q=0 with dac_valid=1, and underflow_err is set. Gap cycles do not count as beats. PLAY lasts until wf_len beats are accepted.
- PLAY, tlast checks:
  - tlast on beat index < wf_len-1: that beat is output, tlast_err is set, and the frame ends early (go to DONE).
  - Beat index wf_len-1 without tlast: tlast_err is set and the frame ends normally.
- DONE: lasts one cycle. frame_done=1, dac_valid=0, dac_i/q=0, frame_count increments (wraps at 2^FCNT_WIDTH). Then go to IDLE. A trigger in this cycle is an overrun.
- dac_valid is 0 in IDLE, WAIT_RDY and DELAY, except the single cycle after the last accepted beat, which carries that sample.
- trigger while not in IDLE: ignored, and trig_overrun_err is set.
- Sticky errors: clear_errors zeroes them. If set and clear occur in the same cycle, set wins.
- busy=1 in every state except IDLE.

Test Plan:
- wf_len=128, start_delay=0, wf_read_ready=1, tvalid always high, tdata=n, tlast on beat 127:
  - first dac_valid 2 cycles after trigger; 128 samples with dac_q=n in order;
  - frame_done one cycle after the last sample; frame_count=1; no error flags.
- start_delay=5, wf_read_ready raised 10 cycles after trigger: first tready exactly 5 cycles after ready rises.
- tvalid low for 3 cycles mid-frame:
  - three zero samples with dac_valid=1 and underflow_err=1;
  - exactly 128 nonzero-data samples, so the frame is 3 cycles longer;
  - clear_errors then drops the flag.
- tlast on beat 63 with wf_len=128: 64 samples, tlast_err=1, frame_done follows, back to IDLE. Second case: no tlast on beat 127 gives tlast_err=1 and a normal end.
- trigger pulsed during PLAY: the frame is unaffected and trig_overrun_err=1. trigger with wf_len=0 in IDLE: busy stays 0.
- aresetn dropped mid-PLAY: tready, dac_valid and busy go 0 asynchronously. After release, a new trigger plays a full frame correctly.
